// File: rtl/sevenseg_pkg.sv
// Shared types and the active-low glyph table for the seven-segment scanner.
package sevenseg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // All segments off (active-low).
  localparam seg_t SEG_BLANK = 7'h7F;

  // Glyph for one nibble, bit order {g,f,e,d,c,b,a}, 0 = segment lit.
  // 10..15 show as hex A,b,C,d,E,F.
  function automatic seg_t glyph(input bcd_t val);
    seg_t s;
    case (val)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_sevenseg_scan_if.sv
// Digit load / display signal bundle between the digit source and the scanner.
interface bcd_sevenseg_scan_if;
  import sevenseg_pkg::*;

  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic        en;
  logic [3:0]  an_n;
  seg_t        seg_n;
  logic        dp_n;
  logic        frame_done;

  modport master (
    output load, bcd_in, dp_in, lz_en, en,
    input  an_n, seg_n, dp_n, frame_done
  );

  modport slave (
    input  load, bcd_in, dp_in, lz_en, en,
    output an_n, seg_n, dp_n, frame_done
  );

endinterface

// File: rtl/sevenseg_decoder.sv
// Combinational nibble to active-low segment pattern.
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  assign seg = glyph(bcd);

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Four-digit multiplexed seven-segment driver: shadow-latched digits,
// one anode per refresh slot, leading-zero blanking, registered outputs.
module bcd_sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int TICK_DIV = 100_000
) (
  input  logic                clk,
  input  logic                reset_n,
  bcd_sevenseg_scan_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    idx;
  logic [15:0]   shadow_bcd;
  logic [3:0]    shadow_dp;
  bcd_t          cur_digit;
  seg_t          cur_seg;
  logic [3:0]    blank;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Free-running slot prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Digit index advances once per slot; frame_done marks the 3->0 wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= 2'd0;
      frame_done_q_clear();
    end else begin
      if (tick) idx <= idx + 2'd1;
      bus.frame_done <= tick && (idx == 2'd3);
    end
  end

  // Shadow copy of the displayed value, updated only on load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_bcd <= 16'h0000;
      shadow_dp  <= 4'h0;
    end else if (bus.load) begin
      shadow_bcd <= bus.bcd_in;
      shadow_dp  <= bus.dp_in;
    end
  end

  assign cur_digit = shadow_bcd[4*idx +: 4];

  sevenseg_decoder u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // Leading-zero blanking: a digit blanks only if it and every digit above it
  // are zero and it carries no decimal point. The ones digit always shows.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = bus.lz_en && (shadow_bcd[15:12] == 4'h0) && !shadow_dp[3];
    blank[2] = bus.lz_en && (shadow_bcd[15:8]  == 8'h00) && !shadow_dp[2];
    blank[1] = bus.lz_en && (shadow_bcd[15:4]  == 12'h000) && !shadow_dp[1];
  end

  // Registered display outputs, one cycle behind idx/shadow/lz_en/en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.an_n  <= 4'hF;
      bus.seg_n <= SEG_BLANK;
      bus.dp_n  <= 1'b1;
    end else if (!bus.en || blank[idx]) begin
      bus.an_n  <= 4'hF;
      bus.seg_n <= SEG_BLANK;
      bus.dp_n  <= 1'b1;
    end else begin
      bus.an_n  <= ~(4'b0001 << idx);
      bus.seg_n <= cur_seg;
      bus.dp_n  <= ~shadow_dp[idx];
    end
  end

  // Reset value of the frame pulse, kept beside the index register it tracks.
  task automatic frame_done_q_clear();
    bus.frame_done <= 1'b0;
  endtask

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Directed self-checking bench for bcd_sevenseg_scan with TICK_DIV=4.
module tb_bcd_sevenseg_scan;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   k;

  bcd_sevenseg_scan_if bus ();

  bcd_sevenseg_scan #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot whose content is visible after edge k (k = edges since reset release).
  function automatic int slot();
    return ((k - 1) / 4) % 4;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic wait_slot(input int s);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (slot() != s && n < 20);
    if (slot() != s) begin
      checks++;
      failures++;
      $display("FAIL wait_slot%0d: observed=timeout expected=slot reached", s);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    bus.bcd_in = v;
    bus.dp_in  = dp;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    k        = 0;
    reset_n  = 1'b0;
    bus.load = 1'b0;
    bus.bcd_in = 16'h0000;
    bus.dp_in  = 4'h0;
    bus.lz_en  = 1'b0;
    bus.en     = 1'b1;

    // 1: reset values, then first update shows digit0 = 0
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {12'h0, bus.an_n}, 16'h000F);
    chk("rst_seg", {9'h0, bus.seg_n}, 16'h007F);
    chk("rst_dp", {15'h0, bus.dp_n}, 16'h0001);
    chk("rst_fd", {15'h0, bus.frame_done}, 16'h0000);
    reset_n = 1'b1;
    k = 0;
    step();
    chk("rel_an", {12'h0, bus.an_n}, 16'h000E);
    chk("rel_seg", {9'h0, bus.seg_n}, 16'h0040);

    // 2: 0255 with leading-zero blanking
    bus.lz_en = 1'b1;
    do_load(16'h0255, 4'h0);
    wait_slot(0);
    chk("t2_s0_an", {12'h0, bus.an_n}, 16'h000E);
    chk("t2_s0_seg", {9'h0, bus.seg_n}, 16'h0012);
    wait_slot(1);
    chk("t2_s1_an", {12'h0, bus.an_n}, 16'h000D);
    chk("t2_s1_seg", {9'h0, bus.seg_n}, 16'h0012);
    wait_slot(2);
    chk("t2_s2_an", {12'h0, bus.an_n}, 16'h000B);
    chk("t2_s2_seg", {9'h0, bus.seg_n}, 16'h0024);
    wait_slot(3);
    chk("t2_s3_an", {12'h0, bus.an_n}, 16'h000F);
    chk("t2_s3_seg", {9'h0, bus.seg_n}, 16'h007F);

    // 3: blanking off shows the leading zero
    bus.lz_en = 1'b0;
    wait_slot(3);
    chk("t3_s3_an", {12'h0, bus.an_n}, 16'h0007);
    chk("t3_s3_seg", {9'h0, bus.seg_n}, 16'h0040);
    chk("t3_s3_dp", {15'h0, bus.dp_n}, 16'h0001);

    // 4: all zero, dp on digit2 keeps it lit
    bus.lz_en = 1'b1;
    do_load(16'h0000, 4'b0100);
    wait_slot(2);
    chk("t4_s2_an", {12'h0, bus.an_n}, 16'h000B);
    chk("t4_s2_seg", {9'h0, bus.seg_n}, 16'h0040);
    chk("t4_s2_dp", {15'h0, bus.dp_n}, 16'h0000);
    wait_slot(3);
    chk("t4_s3_an", {12'h0, bus.an_n}, 16'h000F);
    chk("t4_s3_dp", {15'h0, bus.dp_n}, 16'h0001);
    wait_slot(0);
    chk("t4_s0_an", {12'h0, bus.an_n}, 16'h000E);
    chk("t4_s0_seg", {9'h0, bus.seg_n}, 16'h0040);
    chk("t4_s0_dp", {15'h0, bus.dp_n}, 16'h0001);
    wait_slot(1);
    chk("t4_s1_an", {12'h0, bus.an_n}, 16'h000F);
    chk("t4_s1_seg", {9'h0, bus.seg_n}, 16'h007F);

    // hex glyphs
    bus.lz_en = 1'b0;
    do_load(16'hEDCB, 4'h0);
    wait_slot(0);
    chk("hex_b", {9'h0, bus.seg_n}, 16'h0003);
    wait_slot(1);
    chk("hex_C", {9'h0, bus.seg_n}, 16'h0046);
    wait_slot(2);
    chk("hex_d", {9'h0, bus.seg_n}, 16'h0021);
    wait_slot(3);
    chk("hex_E", {9'h0, bus.seg_n}, 16'h0006);

    // 5: slot timing and frame pulse period
    do_load(16'h1234, 4'h0);
    for (int i = 0; i < 32; i++) begin
      step();
      chk("t5_an", {12'h0, bus.an_n}, {12'h0, ~(4'b0001 << slot())});
      chk("t5_fd", {15'h0, bus.frame_done}, {15'h0, (k % 16) == 0});
    end
    bus.en = 1'b0;
    step();
    chk("t5_off_an", {12'h0, bus.an_n}, 16'h000F);
    chk("t5_off_seg", {9'h0, bus.seg_n}, 16'h007F);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_off_hold", {12'h0, bus.an_n}, 16'h000F);
      chk("t5_off_fd", {15'h0, bus.frame_done}, {15'h0, (k % 16) == 0});
    end
    bus.en = 1'b1;
    step();
    chk("t5_on_an", {12'h0, bus.an_n}, {12'h0, ~(4'b0001 << slot())});

    // 6: asynchronous reset mid-slot clears the shadow
    do_load(16'h8888, 4'hF);
    wait_slot(1);
    step();
    chk("t6_pre_seg", {9'h0, bus.seg_n}, 16'h0000);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_an", {12'h0, bus.an_n}, 16'h000F);
    chk("t6_rst_seg", {9'h0, bus.seg_n}, 16'h007F);
    chk("t6_rst_dp", {15'h0, bus.dp_n}, 16'h0001);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    k = 0;
    step();
    chk("t6_rel_an", {12'h0, bus.an_n}, 16'h000E);
    chk("t6_rel_seg", {9'h0, bus.seg_n}, 16'h0040);
    wait_slot(3);
    chk("t6_s3_an", {12'h0, bus.an_n}, 16'h0007);
    chk("t6_s3_seg", {9'h0, bus.seg_n}, 16'h0040);
    chk("t6_s3_dp", {15'h0, bus.dp_n}, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
